// File: rtl/plic_pkg.sv
// Shared types and constants for the PLIC interrupt gateway array.
package plic_pkg;

   // Width of source and target identifiers on the claim/complete interface.
   localparam int PLIC_ID_W = 5;

   // Per-source gateway state: waiting, pending, or being serviced by a target.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      SERV = 2'd2
   } gw_state_t;

   // Increment that sticks at all-ones instead of wrapping; width fixed by caller.
   function automatic logic [7:0] sat_inc8(input logic [7:0] val, input logic [7:0] max);
      logic [7:0] res;
      res = (val == max) ? val : val + 8'd1;
      return res;
   endfunction

endpackage

// File: rtl/plic_gateway_cell.sv
// One interrupt gateway: input synchroniser, saturating edge counter,
// IDLE/PEND/SERV state machine and the register holding the servicing target.
module plic_gateway_cell
   import plic_pkg::*;
#(
   parameter int SRC_ID      = 1,
   parameter int TGT_N       = 1,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_CNT_W  = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 src_raw,
   input  logic                 cfg_edge,
   input  logic                 claim_valid,
   input  logic [PLIC_ID_W-1:0] claim_src,
   input  logic [PLIC_ID_W-1:0] claim_tgt,
   input  logic                 complete_valid,
   input  logic [PLIC_ID_W-1:0] complete_src,
   input  logic [PLIC_ID_W-1:0] complete_tgt,
   output logic                 pending,
   output logic                 active
);

   localparam logic [PLIC_ID_W-1:0] MY_ID   = PLIC_ID_W'(SRC_ID);
   localparam logic [PLIC_ID_W:0]   TGT_LIM = (PLIC_ID_W + 1)'(TGT_N);
   localparam logic [7:0]           CNT_MAX = 8'((1 << EDGE_CNT_W) - 1);

   logic s;

   if (SYNC_STAGES == 0) begin : g_nosync
      assign s = src_raw;
   end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      logic [SYNC_STAGES-1:0] sync_d;

      // Shift the raw source through the synchroniser chain.
      always_comb begin
         sync_d[0] = src_raw;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
         end
      end

      // Synchroniser flops, cleared on reset so no spurious edge appears.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) sync_q <= '0;
         else        sync_q <= sync_d;
      end

      assign s = sync_q[SYNC_STAGES-1];
   end

   gw_state_t                state_q, state_d;
   logic [EDGE_CNT_W-1:0]    cnt_q, cnt_d;
   logic [PLIC_ID_W-1:0]     owner_q, owner_d;
   logic                     s_prev_q;
   logic                     cfg_prev_q;
   logic                     pend_q, pend_d;
   logic                     act_q, act_d;
   logic                     edge_det;
   logic                     claim_hit;
   logic                     compl_hit;
   logic                     enter_edge;

   // Next-state, counter and owner computation for this source.
   always_comb begin
      edge_det   = s & ~s_prev_q;
      claim_hit  = claim_valid && (claim_src == MY_ID) && ({1'b0, claim_tgt} < TGT_LIM);
      compl_hit  = complete_valid && (complete_src == MY_ID) && (complete_tgt == owner_q);
      state_d    = state_q;
      owner_d    = owner_q;
      enter_edge = 1'b0;

      case (state_q)
         IDLE: begin
            if (cfg_edge) begin
               if (edge_det || (cnt_q != '0)) begin
                  state_d    = PEND;
                  enter_edge = 1'b1;
               end
            end else if (s) begin
               state_d = PEND;
            end
         end
         PEND: begin
            if (claim_hit) begin
               state_d = SERV;
               owner_d = claim_tgt;
            end
         end
         SERV: begin
            if (compl_hit) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A mode change discards stored edges; an edge arriving on the entry
      // cycle replaces the count that entry would otherwise consume.
      if (cfg_edge != cfg_prev_q) begin
         cnt_d = '0;
      end else if (!cfg_edge) begin
         cnt_d = cnt_q;
      end else if (enter_edge) begin
         cnt_d = edge_det ? cnt_q : cnt_q - 1'b1;
      end else if (edge_det) begin
         cnt_d = EDGE_CNT_W'(sat_inc8(8'(cnt_q), CNT_MAX));
      end else begin
         cnt_d = cnt_q;
      end

      pend_d = (state_d == PEND);
      act_d  = (state_d == SERV);
   end

   // Gateway state, counter, owner and registered output flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         owner_q    <= '0;
         s_prev_q   <= 1'b0;
         cfg_prev_q <= 1'b0;
         pend_q     <= 1'b0;
         act_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         owner_q    <= owner_d;
         s_prev_q   <= s;
         cfg_prev_q <= cfg_edge;
         pend_q     <= pend_d;
         act_q      <= act_d;
      end
   end

   assign pending = pend_q;
   assign active  = act_q;

endmodule

// File: rtl/plic_gateway_array.sv
// Array of interrupt gateways feeding pending/in-service flags to the PLIC
// routing array. Source id 0 does not exist, so bit 0 of both outputs is low.
module plic_gateway_array
   import plic_pkg::*;
#(
   parameter int SRC_N       = 31,
   parameter int TGT_N       = 1,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_CNT_W  = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [SRC_N-1:0]     int_src,
   input  logic [SRC_N-1:0]     cfg_edge,
   input  logic                 claim_valid,
   input  logic [PLIC_ID_W-1:0] claim_src,
   input  logic [PLIC_ID_W-1:0] claim_tgt,
   input  logic                 complete_valid,
   input  logic [PLIC_ID_W-1:0] complete_src,
   input  logic [PLIC_ID_W-1:0] complete_tgt,
   output logic [SRC_N:0]       int_pending,
   output logic [SRC_N:0]       int_active
);

   assign int_pending[0] = 1'b0;
   assign int_active[0]  = 1'b0;

   for (genvar i = 1; i <= SRC_N; i++) begin : g_cell
      plic_gateway_cell #(
         .SRC_ID      (i),
         .TGT_N       (TGT_N),
         .SYNC_STAGES (SYNC_STAGES),
         .EDGE_CNT_W  (EDGE_CNT_W)
      ) u_cell (
         .clk            (clk),
         .rst_n          (rst_n),
         .src_raw        (int_src[i-1]),
         .cfg_edge       (cfg_edge[i-1]),
         .claim_valid    (claim_valid),
         .claim_src      (claim_src),
         .claim_tgt      (claim_tgt),
         .complete_valid (complete_valid),
         .complete_src   (complete_src),
         .complete_tgt   (complete_tgt),
         .pending        (int_pending[i]),
         .active         (int_active[i])
      );
   end

endmodule

// File: tb/tb_plic_gateway_array.sv
// Directed bench for plic_gateway_array: 5 sources, 2 targets, 2 sync stages,
// 2-bit edge counter. Source 1 runs in edge mode, the rest in level mode.
module tb_plic_gateway_array;

   localparam int SRC_N       = 5;
   localparam int TGT_N       = 2;
   localparam int SYNC_STAGES = 2;
   localparam int EDGE_CNT_W  = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [SRC_N-1:0] int_src;
   logic [SRC_N-1:0] cfg_edge;
   logic             claim_valid;
   logic [4:0]       claim_src;
   logic [4:0]       claim_tgt;
   logic             complete_valid;
   logic [4:0]       complete_src;
   logic [4:0]       complete_tgt;
   logic [SRC_N:0]   int_pending;
   logic [SRC_N:0]   int_active;

   int n_vec = 0;
   int n_err = 0;

   plic_gateway_array #(
      .SRC_N       (SRC_N),
      .TGT_N       (TGT_N),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_CNT_W  (EDGE_CNT_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .int_src        (int_src),
      .cfg_edge       (cfg_edge),
      .claim_valid    (claim_valid),
      .claim_src      (claim_src),
      .claim_tgt      (claim_tgt),
      .complete_valid (complete_valid),
      .complete_src   (complete_src),
      .complete_tgt   (complete_tgt),
      .int_pending    (int_pending),
      .int_active     (int_active)
   );

   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_p(input string tag, input int idx, input logic exp);
      check(tag, 32'(int_pending[idx]), 32'(exp));
   endtask

   task automatic chk_a(input string tag, input int idx, input logic exp);
      check(tag, 32'(int_active[idx]), 32'(exp));
   endtask

   task automatic chk_vec(input string tag, input logic [SRC_N:0] exp_p, input logic [SRC_N:0] exp_a);
      check({tag, "_pend"}, 32'(int_pending), 32'(exp_p));
      check({tag, "_act"}, 32'(int_active), 32'(exp_a));
   endtask

   task automatic claim(input logic [4:0] src, input logic [4:0] tgt);
      claim_valid = 1'b1;
      claim_src   = src;
      claim_tgt   = tgt;
      tick();
      claim_valid = 1'b0;
      claim_src   = '0;
      claim_tgt   = '0;
   endtask

   task automatic complete(input logic [4:0] src, input logic [4:0] tgt);
      complete_valid = 1'b1;
      complete_src   = src;
      complete_tgt   = tgt;
      tick();
      complete_valid = 1'b0;
      complete_src   = '0;
      complete_tgt   = '0;
   endtask

   task automatic claim_and_complete(input logic [4:0] src, input logic [4:0] tgt);
      claim_valid    = 1'b1;
      claim_src      = src;
      claim_tgt      = tgt;
      complete_valid = 1'b1;
      complete_src   = src;
      complete_tgt   = tgt;
      tick();
      claim_valid    = 1'b0;
      claim_src      = '0;
      claim_tgt      = '0;
      complete_valid = 1'b0;
      complete_src   = '0;
      complete_tgt   = '0;
   endtask

   // One-cycle high pulse on source 1.
   task automatic pulse1();
      int_src[0] = 1'b1;
      tick();
      int_src[0] = 1'b0;
      tick();
   endtask

   initial begin
      rst_n          = 1'b0;
      int_src        = '0;
      cfg_edge       = 5'b00001;
      claim_valid    = 1'b0;
      claim_src      = '0;
      claim_tgt      = '0;
      complete_valid = 1'b0;
      complete_src   = '0;
      complete_tgt   = '0;
      tick();
      tick();
      chk_vec("reset", 6'b000000, 6'b000000);
      rst_n = 1'b1;
      tick();

      // Level source 3: latency, claim, complete with source still high.
      int_src[2] = 1'b1;
      tick();
      tick();
      chk_p("lvl_lat_early", 3, 1'b0);
      tick();
      chk_p("lvl_lat", 3, 1'b1);
      claim(5'd3, 5'd1);
      chk_a("lvl_claim_act", 3, 1'b1);
      chk_p("lvl_claim_pend", 3, 1'b0);
      complete(5'd3, 5'd1);
      chk_vec("lvl_idle_1clk", 6'b000000, 6'b000000);
      tick();
      chk_p("lvl_repend", 3, 1'b1);
      int_src[2] = 1'b0;
      claim(5'd3, 5'd1);
      complete(5'd3, 5'd1);
      tick();
      tick();
      chk_vec("lvl_low_stays_idle", 6'b000000, 6'b000000);

      // Wrong-target complete on source 5.
      int_src[4] = 1'b1;
      tick();
      tick();
      tick();
      chk_p("wt_pend", 5, 1'b1);
      int_src[4] = 1'b0;
      claim(5'd5, 5'd0);
      chk_a("wt_claim", 5, 1'b1);
      complete(5'd5, 5'd1);
      chk_a("wt_wrong_tgt_stays", 5, 1'b1);
      complete(5'd5, 5'd0);
      chk_a("wt_right_tgt", 5, 1'b0);
      tick();
      chk_vec("wt_quiet", 6'b000000, 6'b000000);

      // Ignored traffic with source 2 pending.
      int_src[1] = 1'b1;
      tick();
      tick();
      tick();
      chk_vec("ign_setup", 6'b000100, 6'b000000);
      claim(5'd0, 5'd0);
      chk_vec("ign_claim_zero", 6'b000100, 6'b000000);
      claim(5'd4, 5'd0);
      chk_vec("ign_claim_idle", 6'b000100, 6'b000000);
      complete(5'd31, 5'd0);
      chk_vec("ign_complete_31", 6'b000100, 6'b000000);
      claim(5'd2, 5'd2);
      chk_vec("ign_claim_bad_tgt", 6'b000100, 6'b000000);
      claim(5'd31, 5'd0);
      chk_vec("ign_claim_31", 6'b000100, 6'b000000);

      // Same-cycle claim and complete of one id: only the legal transition fires.
      claim_and_complete(5'd2, 5'd1);
      chk_vec("sim_pend_to_serv", 6'b000000, 6'b000100);
      int_src[1] = 1'b0;
      tick();
      tick();
      claim_and_complete(5'd2, 5'd1);
      chk_vec("sim_serv_to_idle", 6'b000000, 6'b000000);
      tick();
      chk_vec("sim_quiet", 6'b000000, 6'b000000);

      // Edge source 1: saturation at 3 while in service.
      pulse1();
      tick();
      chk_p("edge_first_pend", 1, 1'b1);
      claim(5'd1, 5'd0);
      chk_a("edge_serv", 1, 1'b1);
      for (int n = 0; n < 6; n++) pulse1();
      tick();
      tick();
      tick();
      for (int k = 0; k < 4; k++) begin
         complete(5'd1, 5'd0);
         chk_vec("sat_idle", 6'b000000, 6'b000000);
         tick();
         chk_p("sat_repend", 1, (k < 3));
         if (k < 3) claim(5'd1, 5'd0);
      end

      // Edge landing on the IDLE->PEND entry cycle with cnt = 1.
      pulse1();
      tick();
      chk_p("same_pend", 1, 1'b1);
      claim(5'd1, 5'd0);
      pulse1();
      tick();
      tick();
      int_src[0] = 1'b1;
      tick();
      complete(5'd1, 5'd0);
      int_src[0] = 1'b0;
      chk_vec("same_idle", 6'b000000, 6'b000000);
      tick();
      chk_p("same_entry", 1, 1'b1);
      claim(5'd1, 5'd0);
      complete(5'd1, 5'd0);
      chk_p("same_idle2", 1, 1'b0);
      tick();
      chk_p("same_cnt_kept", 1, 1'b1);
      claim(5'd1, 5'd0);
      complete(5'd1, 5'd0);
      tick();
      tick();
      chk_vec("same_drained", 6'b000000, 6'b000000);

      // Mode change clears stored edges but keeps the state.
      pulse1();
      tick();
      claim(5'd1, 5'd0);
      pulse1();
      pulse1();
      tick();
      tick();
      cfg_edge[0] = 1'b0;
      tick();
      cfg_edge[0] = 1'b1;
      tick();
      chk_a("cfg_keep_state", 1, 1'b1);
      complete(5'd1, 5'd0);
      tick();
      tick();
      chk_vec("cfg_cnt_cleared", 6'b000000, 6'b000000);

      // Asynchronous reset while source 1 is in service with cnt = 2.
      pulse1();
      tick();
      claim(5'd1, 5'd0);
      pulse1();
      pulse1();
      tick();
      tick();
      chk_vec("rst_setup", 6'b000000, 6'b000010);
      #2;
      rst_n = 1'b0;
      #1;
      chk_vec("rst_async", 6'b000000, 6'b000000);
      tick();
      rst_n = 1'b1;
      for (int n = 0; n < 4; n++) tick();
      chk_vec("rst_edges_lost", 6'b000000, 6'b000000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
